// File: rtl/mem_line_responder_pkg.sv
// Shared types and constants for the cache-line memory responder.
// The FSM state encoding and the counter-width helper live here.
package mem_resp_pkg;

   localparam int LINE_W      = 128;
   localparam int LATENCY_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      GAP  = 2'd3
   } state_e;

   // Wide enough to hold LATENCY-1 for any legal latency.
   function automatic int cnt_width(input int latency);
      return $clog2(latency + 1);
   endfunction

   localparam int CNT_W = cnt_width(LATENCY_DEF);

endpackage

// File: rtl/mem_line_responder_if.sv
// Cache-to-memory line refill/writeback handshake.
// The cache is the master; the memory responder is the slave.
interface mem_line_responder_if #(
   parameter int LINE_W = mem_resp_pkg::LINE_W
);

   logic              mem_read;
   logic              mem_write;
   logic [31:4]       mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_read,
      output mem_write,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_read,
      input  mem_write,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ready
   );

endinterface

// File: rtl/mem_line_responder_array.sv
// Line storage: one synchronous write port and one synchronous read port.
// The contents are never reset; unwritten lines read back undefined.
module mem_line_array #(
   parameter int LINE_W     = 128,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_idx,
   input  logic [LINE_W-1:0]     wr_data,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic [LINE_W-1:0]     rd_data
);

   logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];
   logic [LINE_W-1:0] rd_data_q;

   // NOTE: no reset branch here; a reset on a RAM array defeats block-RAM inference.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_idx];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency memory responder for cache line refills and writebacks.
// Accepts one held request, answers with a one-cycle mem_ready pulse, then idles a cycle.
module mem_line_responder
   import mem_resp_pkg::state_e, mem_resp_pkg::IDLE, mem_resp_pkg::WAIT,
          mem_resp_pkg::RESP, mem_resp_pkg::GAP, mem_resp_pkg::cnt_width;
#(
   parameter int LINE_W     = 128,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 8
) (
   input  logic                 clk,
   input  logic                 proc_reset,
   mem_line_responder_if.slave  bus
);

   localparam int CntW = cnt_width(LATENCY);

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  op_wr_q, op_wr_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [LINE_W-1:0]     wdata_q, wdata_d;
   logic                  ready_q, ready_d;

   logic                  arr_rd_en;
   logic [DEPTH_LOG2-1:0] arr_rd_idx;
   logic [LINE_W-1:0]     arr_rd_data;
   logic                  arr_wr_en;
   logic                  addr_unused;

   // Line address bits above the index alias silently.
   assign addr_unused = ^bus.mem_addr[31:DEPTH_LOG2+4];

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_wr_d    = op_wr_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      ready_d    = 1'b0;
      arr_rd_en  = 1'b0;
      arr_rd_idx = idx_q;

      unique case (state_q)
         IDLE: begin
            if (bus.mem_read || bus.mem_write) begin
               // Read and write together resolve to a write.
               op_wr_d = bus.mem_write;
               idx_d   = bus.mem_addr[DEPTH_LOG2+3:4];
               wdata_d = bus.mem_wdata;
               cnt_d   = CntW'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  ready_d    = 1'b1;
                  arr_rd_en  = !bus.mem_write;
                  arr_rd_idx = bus.mem_addr[DEPTH_LOG2+3:4];
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d   = RESP;
               ready_d   = 1'b1;
               arr_rd_en = !op_wr_q;
            end
         end
         RESP:    state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
      end
   end

   // A write lands on the edge leaving RESP, unless that edge is a reset.
   assign arr_wr_en = (state_q == RESP) && op_wr_q && !proc_reset;

   mem_line_array #(
      .LINE_W     (LINE_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .wr_en   (arr_wr_en),
      .wr_idx  (idx_q),
      .wr_data (wdata_q),
      .rd_en   (arr_rd_en),
      .rd_idx  (arr_rd_idx),
      .rd_data (arr_rd_data)
   );

   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = !ready_q ? '0 : (op_wr_q ? wdata_q : arr_rd_data);

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder with a response scoreboard.
// Expected line data and due edges are queued at issue and popped on mem_ready.
module tb_mem_line_responder;

   localparam int LAT = 8;
   localparam int LW  = 128;

   typedef struct {
      logic [LW-1:0] data;
      bit            chk;
      int            due;
      string         tag;
   } exp_t;

   logic   clk = 1'b0;
   logic   proc_reset;
   int     edge_n = 0;
   int     checks = 0;
   int     errors = 0;
   exp_t   sb[$];

   logic [LW-1:0] d1, d2, d4, d5, d6, d_aa, d_55, d_11, d_ee;

   mem_line_responder_if #(.LINE_W(LW)) bus ();

   mem_line_responder #(
      .LINE_W     (LW),
      .DEPTH_LOG2 (10),
      .LATENCY    (LAT)
   ) dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a request at a negedge; gap=1 when issued during the responder's dead cycle.
   task automatic issue(input logic rd, input logic wr, input logic [31:4] addr,
                        input logic [LW-1:0] wdata, input logic [LW-1:0] exp_data,
                        input bit chk, input bit expect_resp, input int gap, input string tag);
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      if (expect_resp) begin
         sb.push_back('{data: exp_data, chk: chk, due: edge_n + 1 + gap + LAT, tag: tag});
      end
   endtask

   // Returns at the negedge of the cycle after the ready pulse, request dropped.
   task automatic wait_resp();
      exp_t e;
      bit   got;
      got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
         @(negedge clk);
         if (bus.mem_ready === 1'b1) begin
            got = 1'b1;
            if (sb.size() == 0) begin
               check("unexpected_ready", 1'b1, 1'b0);
            end else begin
               e = sb.pop_front();
               check({"due_edge_", e.tag}, edge_n + 1, e.due);
               if (e.chk) check({"rdata_", e.tag}, bus.mem_rdata, e.data);
            end
         end else begin
            check("rdata_zero_idle", bus.mem_rdata, '0);
         end
      end
      if (!got) check("ready_timeout", 1'b0, 1'b1);
      @(negedge clk);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      check("single_pulse", bus.mem_ready, 1'b0);
      check("rdata_zero_gap", bus.mem_rdata, '0);
   endtask

   task automatic wr_line(input logic [31:4] addr, input logic [LW-1:0] data, input string tag);
      issue(1'b0, 1'b1, addr, data, data, 1'b1, 1'b1, 0, tag);
      wait_resp();
      @(negedge clk);
   endtask

   task automatic rd_line(input logic [31:4] addr, input logic [LW-1:0] exp, input string tag);
      issue(1'b1, 1'b0, addr, '0, exp, 1'b1, 1'b1, 0, tag);
      wait_resp();
      @(negedge clk);
   endtask

   initial begin
      d1   = 128'h0123456789ABCDEF0123456789ABCDEF;
      d2   = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
      d4   = 128'h4444_0000_4444_0000_4444_0000_4444_0000;
      d5   = 128'h5A5A_0F0F_F0F0_A5A5_1234_5678_9ABC_DEF0;
      d6   = 128'h6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
      d_aa = {16{8'hAA}};
      d_55 = {16{8'h55}};
      d_11 = {16{8'h11}};
      d_ee = {16{8'hEE}};

      // Reset held three edges with a read pending: nothing may respond.
      proc_reset    = 1'b1;
      bus.mem_read  = 1'b1;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      repeat (3) begin
         @(negedge clk);
         check("reset_ready", bus.mem_ready, 1'b0);
         check("reset_rdata", bus.mem_rdata, '0);
      end
      proc_reset = 1'b0;
      // Held read is accepted on the first edge after reset; line 0 is uninitialised.
      issue(1'b1, 1'b0, 28'h0000000, '0, '0, 1'b0, 1'b1, 0, "first_after_reset");
      wait_resp();
      @(negedge clk);

      wr_line(28'h0000010, d1, "wr_0x10");
      rd_line(28'h0000010, d1, "rd_0x10");

      // Writeback then refill with no idle cycle between them.
      wr_line(28'h0000060, d_aa, "preload_0x60");
      issue(1'b0, 1'b1, 28'h0000070, d2, d2, 1'b1, 1'b1, 0, "b2b_wr_0x70");
      wait_resp();
      issue(1'b1, 1'b0, 28'h0000060, '0, d_aa, 1'b1, 1'b1, 1, "b2b_rd_0x60");
      wait_resp();
      @(negedge clk);
      rd_line(28'h0000070, d2, "rd_0x70");

      // Read and write together behave as a write.
      issue(1'b1, 1'b1, 28'h0000020, d_55, d_55, 1'b1, 1'b1, 0, "rw_both_0x20");
      wait_resp();
      @(negedge clk);
      rd_line(28'h0000020, d_55, "rd_0x20");

      // Operands changed after accept must be ignored.
      wr_line(28'h0000040, d4, "preload_0x40");
      issue(1'b0, 1'b1, 28'h0000030, d5, d5, 1'b1, 1'b1, 0, "wr_0x30_moved");
      repeat (3) @(negedge clk);
      bus.mem_addr  = 28'h0000040;
      bus.mem_wdata = d_ee;
      wait_resp();
      @(negedge clk);
      rd_line(28'h0000030, d5, "rd_0x30");
      rd_line(28'h0000040, d4, "rd_0x40_untouched");

      // Reset during WAIT of a write: no pulse, old contents survive.
      wr_line(28'h0000050, d_11, "preload_0x50");
      issue(1'b0, 1'b1, 28'h0000050, d_ee, '0, 1'b0, 1'b0, 0, "aborted_wr");
      repeat (3) @(negedge clk);
      proc_reset    = 1'b1;
      bus.mem_write = 1'b0;
      @(negedge clk);
      proc_reset = 1'b0;
      repeat (12) begin
         @(negedge clk);
         check("abort_no_ready", bus.mem_ready, 1'b0);
      end
      rd_line(28'h0000050, d_11, "rd_0x50_after_abort");

      // Index bits only: line 0x400 aliases line 0x000.
      wr_line(28'h0000400, d6, "wr_0x400");
      rd_line(28'h0000000, d6, "rd_0x000_alias");

      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
